// File: rtl/dac_point_scheduler_pkg.sv
// Shared constants for the galvo DAC point scheduler: SPI word layout,
// FSM state encoding and source priority indices.
package dac_point_scheduler_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CODE_W = 12;
    localparam int unsigned CH_BIT = 15;
    localparam logic [2:0]  CFG_BITS = 3'b011;  // buf=0, ga_n=1, shdn_n=1

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT_A = 3'd1;
    localparam logic [2:0] ST_GAP     = 3'd2;
    localparam logic [2:0] ST_SHIFT_B = 3'd3;
    localparam logic [2:0] ST_LATCH   = 3'd4;
    localparam logic [2:0] ST_DWELL   = 3'd5;

    localparam int unsigned CAL = 0;
    localparam int unsigned GFX = 1;

    function automatic logic [WORD_W-1:0] make_word(input logic ch,
                                                    input logic [CODE_W-1:0] code);
        logic [WORD_W-1:0] w;
        w = '0;
        w[CH_BIT] = ch;
        w[CH_BIT-1 -: 3] = CFG_BITS;
        w[CODE_W-1:0] = code;
        return w;
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Mode-0 SPI word shifter: one 16-bit word per start pulse, MSB first,
// chip select released on the final falling SCLK edge.
module dac_spi_shifter
    import dac_point_scheduler_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_csn,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_done
);

    localparam int unsigned DIV_W = $clog2(SCLK_HALF + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

    logic              r_active;
    logic [DIV_W-1:0]  r_div;
    logic [3:0]        r_bit;
    logic [WORD_W-2:0] r_shreg;
    logic              r_csn;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_shreg  <= '0;
            r_csn    <= 1'b1;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_active <= 1'b1;
                r_csn    <= 1'b0;
                r_sclk   <= 1'b0;
                r_mosi   <= i_word[WORD_W-1];
                r_shreg  <= i_word[WORD_W-2:0];
                r_div    <= '0;
                r_bit    <= '0;
            end else if (r_active) begin
                if (r_div == DIV_LAST) begin
                    r_div  <= '0;
                    r_sclk <= ~r_sclk;
                    // Falling edge: advance data, or end the frame after bit 0
                    if (r_sclk) begin
                        if (r_bit == 4'd15) begin
                            r_active <= 1'b0;
                            r_csn    <= 1'b1;
                            r_mosi   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_mosi  <= r_shreg[WORD_W-2];
                            r_shreg <= {r_shreg[WORD_W-3:0], 1'b0};
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign o_csn  = r_csn;
    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_done = r_done;

endmodule

// File: rtl/dac_point_scheduler.sv
// Arbitrates calibration and renderer points, sends X/Y to the dual DAC,
// latches them with the laser colour and enforces galvo dwell and blanking.
module dac_point_scheduler
    import dac_point_scheduler_pkg::*;
#(
    parameter int unsigned SCLK_HALF     = 2,
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned LATCH_CYCLES  = 4,
    parameter int unsigned DWELL_CYCLES  = 500,
    parameter int unsigned BLANK_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cal_valid,
    input  logic [DATA_W-1:0] cal_x,
    input  logic [DATA_W-1:0] cal_y,
    input  logic [2:0]        cal_rgb,
    output logic              cal_ack,
    input  logic              gfx_valid,
    input  logic [DATA_W-1:0] gfx_x,
    input  logic [DATA_W-1:0] gfx_y,
    input  logic [2:0]        gfx_rgb,
    output logic              gfx_ack,
    output logic              dac_csn,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              dac_latchn,
    output logic [2:0]        laser_rgb,
    output logic              busy,
    output logic              point_done
);

    localparam int unsigned GAP_LEN = 2 * SCLK_HALF;
    localparam int unsigned CNT_MAX_A = (DWELL_CYCLES > LATCH_CYCLES) ? DWELL_CYCLES : LATCH_CYCLES;
    localparam int unsigned CNT_MAX = (CNT_MAX_A > GAP_LEN) ? CNT_MAX_A : GAP_LEN;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned IDLE_W = $clog2(BLANK_TIMEOUT + 1);

    // The shifter's done pulse already occupies the first high cycle of each gap
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_LEN - 2);
    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDLE_W-1:0] BLANK_MAX  = IDLE_W'(BLANK_TIMEOUT);
    localparam logic [IDLE_W-1:0] BLANK_LAST = IDLE_W'(BLANK_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tail;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [DATA_W-1:0] r_y;
    logic [2:0]        r_rgb;
    logic [1:0]        r_ack;
    logic              r_latchn;
    logic [2:0]        r_laser;

    logic              w_grant;
    logic [DATA_W-1:0] w_sel_x;
    logic              w_start;
    logic [WORD_W-1:0] w_word;
    logic              w_done;

    assign w_grant = (r_state == ST_IDLE) && (cal_valid || gfx_valid);
    assign w_sel_x = cal_valid ? cal_x : gfx_x;

    // Word A is built from the live source data so csn can drop in the ack cycle
    always_comb begin
        w_start = 1'b0;
        w_word  = make_word(1'b1, CODE_W'(r_y));
        if (w_grant) begin
            w_start = 1'b1;
            w_word  = make_word(1'b0, CODE_W'(w_sel_x));
        end else if ((r_state == ST_GAP) && (r_cnt == GAP_LAST)) begin
            w_start = 1'b1;
        end
    end

    dac_spi_shifter #(
        .SCLK_HALF (SCLK_HALF)
    ) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_word  (w_word),
        .o_csn   (dac_csn),
        .o_sclk  (dac_sclk),
        .o_mosi  (dac_mosi),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_tail     <= 1'b0;
            r_idle_cnt <= '0;
            r_y        <= '0;
            r_rgb      <= '0;
            r_ack      <= '0;
            r_latchn   <= 1'b1;
            r_laser    <= '0;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_ack[cal_valid ? CAL : GFX] <= 1'b1;
                        r_y        <= cal_valid ? cal_y : gfx_y;
                        r_rgb      <= cal_valid ? cal_rgb : gfx_rgb;
                        r_idle_cnt <= '0;
                        r_state    <= ST_SHIFT_A;
                    end else if (r_idle_cnt != BLANK_MAX) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                        if (r_idle_cnt == BLANK_LAST) begin
                            r_laser <= '0;
                        end
                    end
                end
                ST_SHIFT_A: begin
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT_B;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT_B: begin
                    if (w_done) begin
                        r_tail <= 1'b1;
                        r_cnt  <= '0;
                    end else if (r_tail) begin
                        if (r_cnt == GAP_LAST) begin
                            r_tail   <= 1'b0;
                            r_cnt    <= '0;
                            r_latchn <= 1'b0;
                            r_state  <= ST_LATCH;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_cnt == LATCH_LAST) begin
                        r_cnt    <= '0;
                        r_latchn <= 1'b1;
                        r_laser  <= r_rgb;
                        r_state  <= ST_DWELL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (r_cnt == DWELL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cal_ack    = r_ack[CAL];
    assign gfx_ack    = r_ack[GFX];
    assign dac_latchn = r_latchn;
    assign laser_rgb  = r_laser;
    assign busy       = (r_state != ST_IDLE);
    assign point_done = (r_state == ST_DWELL) && (r_cnt == DWELL_LAST);

endmodule
